// File: rtl/muldiv_unit_pkg.sv
// Shared encodings for the iterative multiply/divide unit: operation
// selects seen on md_op, FSM state codes, and a small magnitude helper.
`timescale 1ns/1ps
package muldiv_unit_pkg;

  localparam logic [2:0] MD_MULT  = 3'd0;
  localparam logic [2:0] MD_MULTU = 3'd1;
  localparam logic [2:0] MD_DIV   = 3'd2;
  localparam logic [2:0] MD_DIVU  = 3'd3;
  localparam logic [2:0] MD_MTHI  = 3'd4;
  localparam logic [2:0] MD_MTLO  = 3'd5;
  localparam logic [2:0] MD_MFHI  = 3'd6;
  localparam logic [2:0] MD_MFLO  = 3'd7;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_FIN  = 2'd2;

  // Magnitude of v when treated as signed; pass-through for unsigned ops.
  function automatic logic [31:0] abs32(input logic [31:0] v, input logic sgn);
    return (sgn && v[31]) ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/muldiv_unit.sv
// Iterative MIPS multiply/divide unit with private HI/LO registers.
// 32-step shift-add multiply and restoring divide on operand magnitudes,
// sign fixup applied once in the FIN cycle.
`timescale 1ns/1ps
module muldiv_unit
  import muldiv_unit_pkg::*;
#(
  parameter int ITER = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [2:0]  md_op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        flush,
  output logic        stall,
  output logic        busy,
  output logic        done,
  output logic [31:0] rd_data,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  // state   | meaning
  // IDLE    | waiting for an instruction; MT*/MF* complete here
  // RUN     | one multiply/divide iteration per cycle
  // FIN     | sign fixup, HI/LO written at the closing edge, done pulses

  localparam int CW = $clog2(ITER);

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] count_q, count_d;
  // p: upper accumulator / partial remainder, q: lower accumulator / quotient,
  // m: multiplicand / divisor magnitude.
  logic [31:0]   p_q, p_d;
  logic [31:0]   q_q, q_d;
  logic [31:0]   m_q, m_d;
  logic          is_div_q, is_div_d;
  logic          qneg_q, qneg_d;
  logic          rneg_q, rneg_d;
  logic          div0_q, div0_d;
  logic [31:0]   hi_q, hi_d;
  logic [31:0]   lo_q, lo_d;

  logic [32:0]   mul_sum;
  logic [32:0]   div_shift;
  logic [31:0]   div_rem;
  logic          div_ge;
  logic [63:0]   prod_fix;
  logic [31:0]   quot_fix;
  logic [31:0]   rem_fix;
  logic          op_signed;

  // One iteration of each datapath, computed from the current registers.
  always_comb begin
    mul_sum   = {1'b0, p_q} + (q_q[0] ? {1'b0, m_q} : 33'd0);
    div_shift = {p_q, q_q[31]};
    div_ge    = (div_shift >= {1'b0, m_q});
    // When div_ge holds the difference is below the divisor, so 32 bits suffice.
    div_rem   = div_shift[31:0] - m_q;
  end

  // Sign fixup of the finished magnitudes; divide-by-zero forces an all-ones quotient.
  always_comb begin
    prod_fix = qneg_q ? (~{p_q, q_q} + 64'd1) : {p_q, q_q};
    quot_fix = div0_q ? 32'hFFFF_FFFF : (qneg_q ? (~q_q + 32'd1) : q_q);
    rem_fix  = rneg_q ? (~p_q + 32'd1) : p_q;
  end

  // Next-state logic for the sequencer, datapath and HI/LO.
  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    p_d       = p_q;
    q_d       = q_q;
    m_d       = m_q;
    is_div_d  = is_div_q;
    qneg_d    = qneg_q;
    rneg_d    = rneg_q;
    div0_d    = div0_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    op_signed = (md_op == MD_MULT) || (md_op == MD_DIV);

    case (state_q)
      ST_IDLE: begin
        if (start && !flush) begin
          case (md_op)
            MD_MULT, MD_MULTU, MD_DIV, MD_DIVU: begin
              p_d      = 32'd0;
              q_d      = abs32(a, op_signed);
              m_d      = abs32(b, op_signed);
              is_div_d = md_op[1];
              qneg_d   = op_signed & (a[31] ^ b[31]);
              rneg_d   = op_signed & a[31];
              div0_d   = (b == 32'd0);
              count_d  = '0;
              state_d  = ST_RUN;
            end
            MD_MTHI: hi_d = a;
            MD_MTLO: lo_d = a;
            default: ;
          endcase
        end
      end
      ST_RUN: begin
        if (flush) begin
          state_d = ST_IDLE;
        end else begin
          if (is_div_q) begin
            p_d = div_ge ? div_rem : div_shift[31:0];
            q_d = {q_q[30:0], div_ge};
          end else begin
            p_d = mul_sum[32:1];
            q_d = {mul_sum[0], q_q[31:1]};
          end
          count_d = count_q + CW'(1);
          if (count_q == CW'(ITER - 1)) state_d = ST_FIN;
        end
      end
      ST_FIN: begin
        state_d = ST_IDLE;
        if (!flush) begin
          if (is_div_q) begin
            hi_d = rem_fix;
            lo_d = quot_fix;
          end else begin
            hi_d = prod_fix[63:32];
            lo_d = prod_fix[31:0];
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      count_q  <= '0;
      p_q      <= 32'd0;
      q_q      <= 32'd0;
      m_q      <= 32'd0;
      is_div_q <= 1'b0;
      qneg_q   <= 1'b0;
      rneg_q   <= 1'b0;
      div0_q   <= 1'b0;
      hi_q     <= 32'd0;
      lo_q     <= 32'd0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      p_q      <= p_d;
      q_q      <= q_d;
      m_q      <= m_d;
      is_div_q <= is_div_d;
      qneg_q   <= qneg_d;
      rneg_q   <= rneg_d;
      div0_q   <= div0_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
    end
  end

  // Pipeline handshake and read-back mux.
  always_comb begin
    busy  = (state_q != ST_IDLE);
    stall = start && (state_q != ST_IDLE);
    done  = (state_q == ST_FIN) && !flush;
    case (md_op)
      MD_MFHI: rd_data = hi_q;
      MD_MFLO: rd_data = lo_q;
      default: rd_data = 32'd0;
    endcase
  end

  assign hi = hi_q;
  assign lo = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Randomised scoreboard bench for muldiv_unit against an arithmetic reference.
`timescale 1ns/1ps
module tb_muldiv_unit;
  import muldiv_unit_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n, start, flush;
  logic [2:0]  md_op;
  logic [31:0] a, b;
  logic        stall, busy, done;
  logic [31:0] rd_data, hi, lo;

  muldiv_unit #(.ITER(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .md_op(md_op), .a(a), .b(b),
    .flush(flush), .stall(stall), .busy(busy), .done(done),
    .rd_data(rd_data), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  logic [63:0] exp_q[$];
  logic [31:0] hi_m, lo_m;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Architectural result {hi, lo} straight from the instruction definitions.
  function automatic logic [63:0] ref_model(input logic [2:0] op, input logic [31:0] x,
                                            input logic [31:0] y);
    longint          sx, sy;
    longint unsigned ux, uy;
    int              sa, sb, qi, ri;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    ux = {32'd0, x};
    uy = {32'd0, y};
    sa = $signed(x);
    sb = $signed(y);
    case (op)
      MD_MULT:  return sx * sy;
      MD_MULTU: return ux * uy;
      MD_DIV: begin
        if (y == 32'd0) return {x, 32'hFFFF_FFFF};
        if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
        qi = sa / sb;
        ri = sa % sb;
        return {ri, qi};
      end
      MD_DIVU: begin
        if (y == 32'd0) return {x, 32'hFFFF_FFFF};
        return {x % y, x / y};
      end
      default: return 64'd0;
    endcase
  endfunction

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 7))
      0:       return 32'd0;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'd1;
      4:       return $urandom_range(0, 20);
      default: return $urandom;
    endcase
  endfunction

  // Monitor: every done pulse retires the oldest expected result.
  logic [63:0] mon_e;
  always @(negedge clk) begin
    if (rst_n && done) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_done: got done=1 expected no operation pending");
      end else begin
        mon_e = exp_q.pop_front();
        @(posedge clk);
        #1;
        check32("result_hi", hi, mon_e[63:32]);
        check32("result_lo", lo, mon_e[31:0]);
      end
    end
  end

  task automatic run_op(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y,
                        input bit chk_timing);
    int cyc, busy_n, done_n, done_at;
    @(negedge clk);
    start = 1'b1; md_op = op; a = x; b = y;
    exp_q.push_back(ref_model(op, x, y));
    {hi_m, lo_m} = ref_model(op, x, y);
    @(negedge clk);
    start = 1'b0;
    cyc = 0; busy_n = 0; done_n = 0; done_at = 0;
    while (busy && cyc < 100) begin
      cyc++;
      busy_n++;
      if (done) begin done_n++; done_at = cyc; end
      @(negedge clk);
    end
    if (cyc >= 100) begin
      checks++; failures++;
      $display("FAIL op_timeout: got busy after %0d cycles expected idle", cyc);
    end
    if (chk_timing) begin
      check32("busy_cycles", busy_n, 32'd33);
      check32("done_cycles", done_n, 32'd1);
      check32("done_position", done_at, 32'd33);
    end
  endtask

  task automatic mt(input logic [2:0] op, input logic [31:0] v);
    @(negedge clk);
    start = 1'b1; md_op = op; a = v;
    #1 check32("mt_stall", stall, 32'd0);
    @(negedge clk);
    start = 1'b0;
    if (op == MD_MTHI) hi_m = v; else lo_m = v;
    check32("mt_busy", busy, 32'd0);
    check32("mt_hi", hi, hi_m);
    check32("mt_lo", lo, lo_m);
  endtask

  task automatic mf(input logic [2:0] op);
    @(negedge clk);
    start = 1'b1; md_op = op;
    #1;
    check32(op == MD_MFHI ? "mfhi_data" : "mflo_data", rd_data,
            op == MD_MFHI ? hi_m : lo_m);
    check32("mf_stall", stall, 32'd0);
    @(negedge clk);
    start = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish expected completion within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, done_n;
    logic [2:0] op;
    rst_n = 1'b0; start = 1'b0; flush = 1'b0; md_op = MD_MULT; a = 32'd0; b = 32'd0;
    hi_m = 32'd0; lo_m = 32'd0;
    repeat (2) @(negedge clk);
    check32("reset_hi", hi, 32'd0);
    check32("reset_lo", lo, 32'd0);
    check32("reset_busy", busy, 32'd0);
    check32("reset_done", done, 32'd0);
    check32("reset_rd_data", rd_data, 32'd0);
    rst_n = 1'b1;

    run_op(MD_MULT,  32'hFFFF_FFFE, 32'd3, 1'b1);
    run_op(MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    run_op(MD_DIV,   32'hFFFF_FFF9, 32'd2, 1'b0);
    run_op(MD_DIVU,  32'd7, 32'd0, 1'b0);
    run_op(MD_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    run_op(MD_DIV,   32'h8000_0005, 32'd0, 1'b0);
    run_op(MD_DIV,   32'd100, 32'hFFFF_FFF9, 1'b1);

    mt(MD_MTHI, 32'h0000_1234);
    mf(MD_MFHI);
    mt(MD_MTLO, 32'hCAFE_F00D);
    mf(MD_MFLO);

    // MTHI squashed in the same cycle must not write HI.
    @(negedge clk);
    start = 1'b1; md_op = MD_MTHI; a = 32'hDEAD_BEEF; flush = 1'b1;
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    check32("flushed_mthi_hi", hi, hi_m);

    // Dependent MFLO issued at k+5 stalls through k+33, releases at k+34.
    @(negedge clk);
    start = 1'b1; md_op = MD_MULT; a = 32'h0001_2345; b = 32'hFFFF_0F0F;
    exp_q.push_back(ref_model(MD_MULT, a, b));
    {hi_m, lo_m} = ref_model(MD_MULT, a, b);
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    start = 1'b1; md_op = MD_MFLO;
    n = 0;
    while (n < 100) begin
      #1;
      if (!stall) break;
      n++;
      @(negedge clk);
    end
    check32("stall_cycles", n, 32'd29);
    check32("released_mflo", rd_data, lo_m);
    @(negedge clk);
    start = 1'b0;

    // Flush at k+10 of a DIV: idle next cycle, no done, HI/LO untouched.
    @(negedge clk);
    start = 1'b1; md_op = MD_DIV; a = 32'h7654_3210; b = 32'd13;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check32("flush_busy", busy, 32'd0);
    done_n = 0;
    repeat (30) begin
      if (done) done_n++;
      @(negedge clk);
    end
    check32("flush_done", done_n, 32'd0);
    check32("flush_hi", hi, hi_m);
    check32("flush_lo", lo, lo_m);

    // Reset mid-RUN clears everything.
    @(negedge clk);
    start = 1'b1; md_op = MD_MULTU; a = 32'h1234_5678; b = 32'h9ABC_DEF0;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0; md_op = MD_MFHI;
    @(negedge clk);
    check32("midrun_reset_hi", hi, 32'd0);
    check32("midrun_reset_lo", lo, 32'd0);
    check32("midrun_reset_busy", busy, 32'd0);
    check32("midrun_reset_done", done, 32'd0);
    check32("midrun_reset_rd_data", rd_data, 32'd0);
    rst_n = 1'b1;
    hi_m = 32'd0; lo_m = 32'd0;

    for (int i = 0; i < 30; i++) begin
      op = 3'($urandom_range(0, 3));
      run_op(op, pick_operand(), pick_operand(), (i % 10) == 0);
      if (i % 7 == 3) mf($urandom_range(0, 1) ? MD_MFHI : MD_MFLO);
      if (i % 11 == 5) mt($urandom_range(0, 1) ? MD_MTHI : MD_MTLO, $urandom);
    end

    repeat (3) @(negedge clk);
    if (exp_q.size() != 0) begin
      checks++; failures++;
      $display("FAIL pending_results: got %0d outstanding expected 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
